pipelined_cla_addsub: RTL and testbench
=======================================

# pipelined_cla_addsub

Parametrised, pipelined carry-look-ahead adder/subtractor with valid/ready flow control and status flags. It is the registered successor to the team's 32-bit combinational CLA.
- The operand width is split into fixed-size segments; each pipeline stage resolves one segment with internal 4-bit look-ahead groups and registers the inter-segment carry.
- Throughput is one operation per cycle.
- It sits between an operand source and a result consumer in the lab datapath.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SEG_W.
- SEG_W, 8, bits resolved per pipeline stage; must be a multiple of 4. NSEG = WIDTH/SEG_W is the stage count.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0: A+B; 1: A−B.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  unsigned carry out; for sub, 1 = no borrow.
- ovf  out  1  signed (two's-complement) overflow.
- zero  out  1  sum == 0, after any saturation.

## Operation
- Subtraction: B is inverted and carry-in is set to 1. Add: carry-in is 0.
- Stage k (1..NSEG):
  - computes sum bits [k·SEG_W−1 : (k−1)·SEG_W] from the delayed operands and the registered carry of stage k−1;
  - uses 4-bit generate/propagate groups with look-ahead across groups inside the segment.
- The upper operand bits and `sub` travel alongside the data in delay registers.
- Flags are computed in stage NSEG:
  - cout = carry out of the MSB;
  - ovf = carry into MSB XOR carry out of MSB;
  - zero = NOR of the final sum.
- Each stage holds a valid bit. Bubbles, where in_valid=0 at an accept opportunity, propagate as invalid entries.
- Global advance: en = !out_valid || out_ready. in_ready = en.
  - When en=0, every stage register holds its value, including invalid ones.
- A beat is accepted on an edge where in_valid && in_ready. No combinational path exists from in_valid to in_ready.
- Results emerge in acceptance order; none are dropped or duplicated.

## Timing
- Latency: a beat accepted at edge t is presented with out_valid=1 after edge t+NSEG−1 (NSEG cycles, counting the accept edge). For defaults, NSEG=4.
- Output hold: outputs stay stable while out_valid && !out_ready.
- Reset:
  - rst=1 at an edge clears all stage valid bits;
  - afterwards out_valid=0, sum=0, cout=0, ovf=0, zero=0;
  - in_ready=1 from the cycle after reset.
- Reset mid-operation: all in-flight beats are discarded. A beat presented in the same cycle as rst=1 is not accepted.
- Simultaneous accept and output: when out_valid && out_ready && in_valid, input is accepted and output retired on the same edge. Full throughput is sustained.
- Wrap-around: without saturation, results wrap modulo 2^WIDTH.

## Configuration
- CLA_SAT_EN defined:
  - when ovf=1, stage NSEG replaces sum with the signed limit: 0x7FF…F if the true result is positive, 0x800…0 if negative;
  - ovf and cout still report the raw condition;
  - zero reflects the saturated sum.
- CLA_SAT_EN undefined: sum is the raw wrapped result and the saturation logic is absent.

## Test plan
- Add, no stall: a=0x8ED56AC8, b=0x7DA662A9, sub=0 → after 4 cycles sum=0x0C7BCD71, cout=1, ovf=0, zero=0.
- Overflow: a=0x7FFFFFFF, b=0x00000001, add → ovf=1, cout=0.
  - Without CLA_SAT_EN: sum=0x80000000.
  - With CLA_SAT_EN: sum=0x7FFFFFFF.
- Subtract:
  - 5−5 → sum=0, zero=1, cout=1.
  - 0−1 → sum=0xFFFFFFFF, cout=0, ovf=0.
  - 0x80000000−1 → ovf=1 (saturated build: sum=0x80000000).
- Back-pressure: stream 8 beats (a=i, b=i) with out_ready held low for 3 cycles mid-stream → in_ready drops, no beat lost or reordered, results 2i in order.
- Bubbles and reset: alternate in_valid=1/0 with out_ready=1 → out_valid alternates with 4-cycle lag. Assert rst with 3 beats in flight → out_valid=0 next cycle and no stale result ever appears.
- Parameter sweep: WIDTH=16, SEG_W=4 → 4-cycle latency; 0xFFFF+0x0001 gives sum=0, cout=1, zero=1.

Source files
------------

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-look-ahead adder/subtractor, one SEG_W segment per stage.
// Optional signed saturation of the result when CLA_SAT_EN is defined.
module pipelined_cla_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NSEG = WIDTH / SEG_W;
    localparam int NGRP = SEG_W / 4;
    localparam int NP   = (NSEG > 1) ? NSEG - 1 : 1;

    // One segment: returns {carry into MSB, carry out, sum bits}.
    function automatic logic [SEG_W+1:0] cla_seg(
        input logic [SEG_W-1:0] x,
        input logic [SEG_W-1:0] y,
        input logic             cin
    );
        logic [SEG_W-1:0] g;
        logic [SEG_W-1:0] p;
        logic [NGRP-1:0]  gg;
        logic [NGRP-1:0]  gp;
        logic [NGRP:0]    gc;
        logic [SEG_W:0]   c;
        logic             pp;
        g = x & y;
        p = x ^ y;
        for (int j = 0; j < NGRP; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        gc[0] = cin;
        for (int j = 0; j < NGRP; j++) begin
            gc[j+1] = gg[j];
            pp = gp[j];
            for (int i = j - 1; i >= 0; i--) begin
                gc[j+1] = gc[j+1] | (pp & gg[i]);
                pp = pp & gp[i];
            end
            gc[j+1] = gc[j+1] | (pp & cin);
        end
        c = '0;
        for (int j = 0; j < NGRP; j++) begin
            c[4*j] = gc[j];
            for (int i = 0; i < 3; i++) begin
                c[4*j+i+1] = g[4*j+i] | (p[4*j+i] & c[4*j+i]);
            end
        end
        c[SEG_W] = gc[NGRP];
        return {c[SEG_W-1], c[SEG_W], p ^ c[SEG_W-1:0]};
    endfunction

    logic             en;
    logic             r_v [NSEG];
    logic [WIDTH-1:0] r_a [NP];
    logic [WIDTH-1:0] r_b [NP];
    logic [WIDTH-1:0] r_s [NP];
    logic             r_c [NP];
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic [WIDTH-1:0] w_a   [NSEG];
    logic [WIDTH-1:0] w_b   [NSEG];
    logic [WIDTH-1:0] w_s   [NSEG];
    logic             w_c   [NSEG];
    logic [SEG_W+1:0] w_res [NSEG];
    logic [WIDTH-1:0] w_new [NSEG];
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_fin;
    logic             w_ovf;

    assign en        = !r_v[NSEG-1] || out_ready;
    assign in_ready  = en;
    assign out_valid = r_v[NSEG-1];
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

    // Per-stage operand sources and segment results; operands are
    // shifted down each stage so the active segment is always at bit 0.
    always_comb begin
        w_a[0] = a;
        w_b[0] = b ^ {WIDTH{sub}};
        w_c[0] = sub;
        w_s[0] = '0;
        for (int k = 1; k < NSEG; k++) begin
            w_a[k] = r_a[k-1];
            w_b[k] = r_b[k-1];
            w_c[k] = r_c[k-1];
            w_s[k] = r_s[k-1];
        end
        for (int k = 0; k < NSEG; k++) begin
            w_res[k] = cla_seg(w_a[k][SEG_W-1:0],
                               w_b[k][SEG_W-1:0],
                               w_c[k]);
            w_new[k] = w_s[k];
            w_new[k][k*SEG_W +: SEG_W] = w_res[k][SEG_W-1:0];
        end
    end

    assign w_raw = w_new[NSEG-1];
    assign w_ovf = w_res[NSEG-1][SEG_W+1] ^ w_res[NSEG-1][SEG_W];

`ifdef CLA_SAT_EN
    logic w_neg;
    // On overflow both operands share a sign, which is the true sign.
    assign w_neg = w_a[NSEG-1][SEG_W-1];

    // Clamp to the signed limit on overflow.
    always_comb begin
        w_fin = w_raw;
        if (w_ovf) begin
            w_fin = w_neg ? {1'b1, {(WIDTH-1){1'b0}}}
                          : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_fin = w_raw;
`endif

    // Pipeline registers; the whole pipe advances together on en.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSEG; k++) r_v[k] <= 1'b0;
            for (int k = 0; k < NP; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
            end
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (en) begin
            r_v[0] <= in_valid;
            for (int k = 1; k < NSEG; k++) r_v[k] <= r_v[k-1];
            for (int k = 0; k < NSEG - 1; k++) begin
                r_a[k] <= w_a[k] >> SEG_W;
                r_b[k] <= w_b[k] >> SEG_W;
                r_s[k] <= w_new[k];
                r_c[k] <= w_res[k][SEG_W];
            end
            r_sum  <= w_fin;
            r_cout <= w_res[NSEG-1][SEG_W];
            r_ovf  <= w_ovf;
            r_zero <= ~|w_fin;
        end
    end
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed bench for pipelined_cla_addsub (32/8 default and 16/4 sweep).
// Expected values are hand-computed; CLA_SAT_EN selects saturated sums.
module tb_pipelined_cla_addsub;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, sub, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic        cout, ovf, zero;
    logic        v16, r16, s16, ov16, ordy16, co16, of16, z16;
    logic [15:0] a16, b16, sum16;
    int          errors = 0;
    int          checks = 0;

`ifdef CLA_SAT_EN
    localparam logic [31:0] E_OVF_ADD = 32'h7FFFFFFF;
    localparam logic [31:0] E_OVF_SUB = 32'h80000000;
`else
    localparam logic [31:0] E_OVF_ADD = 32'h80000000;
    localparam logic [31:0] E_OVF_SUB = 32'h7FFFFFFF;
`endif

    always #5 clk = ~clk;

    pipelined_cla_addsub #(.WIDTH(32), .SEG_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    pipelined_cla_addsub #(.WIDTH(16), .SEG_W(4)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(v16), .in_ready(r16),
        .a(a16), .b(b16), .sub(s16),
        .out_valid(ov16), .out_ready(ordy16),
        .sum(sum16), .cout(co16), .ovf(of16), .zero(z16)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op32(input string tag, input logic [31:0] ta,
                        input logic [31:0] tb_, input logic ts,
                        input logic [31:0] es, input logic ec,
                        input logic eo, input logic ez);
        a = ta; b = tb_; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
        tick();
        tick();
        chk({tag, "_lat3"}, 64'(out_valid), 64'd0);
        tick();
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_sum"}, 64'(sum), 64'(es));
        chk({tag, "_cout"}, 64'(cout), 64'(ec));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
        chk({tag, "_zero"}, 64'(zero), 64'(ez));
        tick();
        chk({tag, "_retired"}, 64'(out_valid), 64'd0);
    endtask

    task automatic op16(input string tag, input logic [15:0] ta,
                        input logic [15:0] tb_, input logic ts,
                        input logic [15:0] es, input logic ec,
                        input logic eo, input logic ez);
        a16 = ta; b16 = tb_; s16 = ts; v16 = 1'b1; ordy16 = 1'b1;
        tick();
        v16 = 1'b0;
        tick();
        tick();
        chk({tag, "_lat3"}, 64'(ov16), 64'd0);
        tick();
        chk({tag, "_valid"}, 64'(ov16), 64'd1);
        chk({tag, "_sum"}, 64'(sum16), 64'(es));
        chk({tag, "_cout"}, 64'(co16), 64'(ec));
        chk({tag, "_ovf"}, 64'(of16), 64'(eo));
        chk({tag, "_zero"}, 64'(z16), 64'(ez));
        tick();
    endtask

    initial begin
        logic        seen;
        logic        drop;
        logic        pstall;
        logic [31:0] held;
        logic [11:0] vpat;
        int          nxt;
        int          rc;

        rst = 1'b1;
        in_valid = 1'b1; a = 32'd5; b = 32'd5; sub = 1'b0;
        out_ready = 1'b1;
        v16 = 1'b1; a16 = 16'd3; b16 = 16'd4; s16 = 1'b0;
        ordy16 = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        v16 = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_flags", 64'({cout, ovf, zero}), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            seen = seen | out_valid | ov16;
        end
        chk("rst_beat_dropped", 64'(seen), 64'd0);

        op32("add", 32'h8ED56AC8, 32'h7DA662A9, 1'b0,
             32'h0C7BCD71, 1'b1, 1'b0, 1'b0);
        op32("add_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0,
             E_OVF_ADD, 1'b0, 1'b1, 1'b0);
        op32("sub_eq", 32'd5, 32'd5, 1'b1,
             32'h0, 1'b1, 1'b0, 1'b1);
        op32("sub_borrow", 32'd0, 32'd1, 1'b1,
             32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        op32("sub_ovf", 32'h80000000, 32'd1, 1'b1,
             E_OVF_SUB, 1'b1, 1'b1, 1'b0);
        op32("add_wrap", 32'hFFFFFFFF, 32'd1, 1'b0,
             32'h0, 1'b1, 1'b0, 1'b1);

        nxt = 0; rc = 0; drop = 1'b0; pstall = 1'b0; held = '0;
        for (int c = 0; c < 40 && rc < 8; c++) begin
            in_valid = (nxt < 8);
            a = 32'(nxt); b = 32'(nxt); sub = 1'b0;
            out_ready = !(c >= 6 && c < 9);
            #1;
            if (out_valid && !in_ready) drop = 1'b1;
            if (pstall) chk("bp_hold", 64'(sum), 64'(held));
            if (out_valid && out_ready) begin
                chk("bp_order", 64'(sum), 64'(2 * rc));
                rc++;
            end
            if (in_valid && in_ready) nxt++;
            pstall = out_valid && !out_ready;
            held = sum;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", 64'(rc), 64'd8);
        chk("bp_ready_drop", 64'(drop), 64'd1);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            seen = seen | out_valid;
        end
        chk("bp_no_dup", 64'(seen), 64'd0);

        vpat = '0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 8) && (c % 2 == 0);
            vpat[c] = in_valid;
            a = 32'(c); b = 32'd1; sub = 1'b0;
            #1;
            if (c >= 4) begin
                chk("bub_valid", 64'(out_valid), 64'(vpat[c-4]));
                if (vpat[c-4])
                    chk("bub_sum", 64'(sum), 64'(c - 3));
            end else begin
                chk("bub_fill", 64'(out_valid), 64'd0);
            end
            tick();
        end
        in_valid = 1'b0;

        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            a = 32'(100 + c); b = 32'd0;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_sum", 64'(sum), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            seen = seen | out_valid;
        end
        chk("mid_rst_stale", 64'(seen), 64'd0);

        op16("w16_wrap", 16'hFFFF, 16'h0001, 1'b0,
             16'h0000, 1'b1, 1'b0, 1'b1);
        op16("w16_add", 16'h1234, 16'h0FF0, 1'b0,
             16'h2224, 1'b0, 1'b0, 1'b0);
        op16("w16_sub", 16'h0003, 16'h0005, 1'b1,
             16'hFFFE, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
